// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS/DIV registers, a small TX FIFO and a serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FFE0,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memAddress,
    input  logic [31:0] memWriteData,
    input  logic        memWrite,
    input  logic [3:0]  byteMask,
    output logic [31:0] memReadData,
    output logic        tx
);
    localparam int unsigned   AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned   PW        = AW + 1;
    localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [29:0]   WA_DATA   = BASE_ADDR[31:2];
    localparam logic [29:0]   WA_STATUS = BASE_ADDR[31:2] + 30'd1;
    localparam logic [29:0]   WA_DIV    = BASE_ADDR[31:2] + 30'd2;
    localparam logic [15:0]   DIV_RST   = 16'(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
    localparam logic          PARITY_PRESENT = 1'b1;
`else
    localparam logic          PARITY_PRESENT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t        r_state;
    state_t        w_state_n;
    logic [7:0]    r_shift, w_shift_n;
    logic [2:0]    r_bit_idx, w_bit_idx_n;
    logic [15:0]   r_cnt, w_cnt_n;
    logic          r_parity, w_parity_n;
    logic          r_tx, w_tx_n;
    logic [15:0]   r_div;
    logic          r_ovf;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;

    logic          w_sel_data, w_sel_status, w_sel_div;
    logic          w_push_req, w_push, w_drop, w_pop, w_ovf_clr, w_div_wr;
    logic          w_full, w_empty, w_busy, w_bit_done;
    logic [PW-1:0] w_count;
    logic [7:0]    w_head;
    logic [15:0]   w_div_eff, w_cnt_load;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_sel_data   = (memAddress[31:2] == WA_DATA);
    assign w_sel_status = (memAddress[31:2] == WA_STATUS);
    assign w_sel_div    = (memAddress[31:2] == WA_DIV);

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_count == DEPTH_P);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
    assign w_busy     = (r_state != S_IDLE);

    // A push into a full FIFO survives only if the serialiser drains an entry on the same edge.
    assign w_push_req = memWrite && w_sel_data && byteMask[0];
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = memWrite && w_sel_status && byteMask[0] && memWriteData[3];
    assign w_div_wr   = memWrite && w_sel_div;

    assign w_div_eff  = (r_div == 16'd0) ? 16'd1 : r_div;
    assign w_cnt_load = w_div_eff - 16'd1;
    assign w_bit_done = (r_cnt == 16'd0);

    assign w_unused   = ^{memWriteData[31:16], byteMask[3:2], memAddress[1:0]};

    // Next-state logic of the serialiser; the baud count is reloaded from DIV at every bit start.
    always_comb begin
        w_state_n   = r_state;
        w_shift_n   = r_shift;
        w_bit_idx_n = r_bit_idx;
        w_cnt_n     = r_cnt;
        w_parity_n  = r_parity;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_state_n  = S_START;
                    w_shift_n  = w_head;
                    w_parity_n = even_parity(w_head);
                    w_cnt_n    = w_cnt_load;
                end else begin
                    w_state_n  = S_IDLE;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_n   = S_DATA;
                    w_bit_idx_n = 3'd0;
                    w_cnt_n     = w_cnt_load;
                end else begin
                    w_cnt_n     = r_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_cnt_n = w_cnt_load;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end else begin
                        w_shift_n   = {1'b0, r_shift[7:1]};
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_n = r_cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_n = S_STOP;
                    w_cnt_n   = w_cnt_load;
                end else begin
                    w_cnt_n   = r_cnt - 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_state_n  = S_START;
                        w_shift_n  = w_head;
                        w_parity_n = even_parity(w_head);
                        w_cnt_n    = w_cnt_load;
                    end else begin
                        w_state_n  = S_IDLE;
                    end
                end else begin
                    w_cnt_n = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so tx is a clean register output.
    always_comb begin
        w_tx_n = 1'b1;
        case (w_state_n)
            S_IDLE:   w_tx_n = 1'b1;
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_shift_n[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_n = w_parity_n;
`endif
            S_STOP:   w_tx_n = 1'b1;
            default:  w_tx_n = 1'b1;
        endcase
    end

    // Serialiser state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_shift   <= 8'd0;
            r_bit_idx <= 3'd0;
            r_cnt     <= 16'd0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_shift   <= w_shift_n;
            r_bit_idx <= w_bit_idx_n;
            r_cnt     <= w_cnt_n;
            r_parity  <= w_parity_n;
            r_tx      <= w_tx_n;
        end
    end

    // FIFO storage/pointers and the DIV / sticky overflow control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            r_div    <= DIV_RST;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem[i] <= 8'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= memWriteData[7:0];
                r_wr_ptr                <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_ovf_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_div_wr && byteMask[0]) begin
                r_div[7:0] <= memWriteData[7:0];
            end
            if (w_div_wr && byteMask[1]) begin
                r_div[15:8] <= memWriteData[15:8];
            end
        end
    end

    // Combinational read mux; DATA and unmapped addresses read as zero.
    always_comb begin
        w_rdata = 32'd0;
        if (w_sel_status) begin
            w_rdata = {27'd0, PARITY_PRESENT, r_ovf, w_empty, w_full, w_busy};
        end else if (w_sel_div) begin
            w_rdata = {16'd0, r_div};
        end else begin
            w_rdata = 32'd0;
        end
    end

    assign memReadData = w_rdata;
    assign tx          = r_tx;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomised self-checking bench for uart_tx_mmio against a queue-based line-level reference model.
`timescale 1ns/1ps
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE   = 32'hFFFF_FFE0;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_DIV  = BASE + 32'd8;
    localparam int          DEPTH  = 4;
`ifdef UART_TX_PARITY_EN
    localparam logic        HAS_PAR = 1'b1;
`else
    localparam logic        HAS_PAR = 1'b0;
`endif
    localparam logic [31:0] PBIT = HAS_PAR ? 32'h10 : 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] memAddress = A_STAT;
    logic [31:0] memWriteData = 32'd0;
    logic        memWrite = 1'b0;
    logic [3:0]  byteMask = 4'd0;
    logic [31:0] memReadData;
    logic        tx;

    int checks = 0;
    int failures = 0;

    // Reference model: bytes waiting to be sent and the per-clock line levels still owed.
    logic [7:0]  m_q[$];
    bit          m_stream[$];
    logic        m_tx = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_div = 16'd16;

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (16),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .byteMask     (byteMask),
        .memReadData  (memReadData),
        .tx           (tx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {27'd0, HAS_PAR, m_ovf, (m_q.size() == 0), (m_q.size() == DEPTH), m_busy};
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a[31:2] == A_STAT[31:2]) return exp_status();
        else if (a[31:2] == A_DIV[31:2]) return {16'd0, m_div};
        else return 32'd0;
    endfunction

    // Expected line level during bit slot k of a frame carrying byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        else if (k <= 8) return d[k-1];
        else if (HAS_PAR && k == 9) return ^d;
        else return 1'b1;
    endfunction

    task automatic model_step();
        logic [7:0] b;
        int         d;
        bit         fb[$];
        if (!reset) begin
            m_q.delete();
            m_stream.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
            m_ovf  = 1'b0;
            m_div  = 16'd16;
        end else begin
            if (m_stream.size() == 0 && m_q.size() != 0) begin
                b = m_q.pop_front();
                d = (m_div == 16'd0) ? 1 : int'(m_div);
                fb.push_back(1'b0);
                for (int i = 0; i < 8; i++) fb.push_back(b[i]);
                if (HAS_PAR) fb.push_back(^b);
                fb.push_back(1'b1);
                foreach (fb[j]) repeat (d) m_stream.push_back(fb[j]);
            end
            if (m_stream.size() != 0) begin
                m_tx   = m_stream.pop_front();
                m_busy = 1'b1;
            end else begin
                m_tx   = 1'b1;
                m_busy = 1'b0;
            end
            if (memWrite) begin
                if (memAddress[31:2] == A_DATA[31:2] && byteMask[0]) begin
                    if (m_q.size() < DEPTH) m_q.push_back(memWriteData[7:0]);
                    else m_ovf = 1'b1;
                end
                if (memAddress[31:2] == A_STAT[31:2] && byteMask[0] && memWriteData[3]) m_ovf = 1'b0;
                if (memAddress[31:2] == A_DIV[31:2] && byteMask[0]) m_div[7:0] = memWriteData[7:0];
                if (memAddress[31:2] == A_DIV[31:2] && byteMask[1]) m_div[15:8] = memWriteData[15:8];
            end
        end
    endtask

    // Advance the model on every edge and compare tx (and STATUS when parked there) each clock.
    initial begin
        forever begin
            @(posedge clk or negedge reset);
            model_step();
            if (reset) begin
                #2;
                if (reset) begin
                    check_eq("tx_cycle", {31'd0, tx}, {31'd0, m_tx});
                    if (memAddress === A_STAT && memWrite === 1'b0)
                        check_eq("status_cycle", memReadData, exp_status());
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        memAddress   = a;
        memWriteData = d;
        byteMask     = m;
        memWrite     = 1'b1;
        @(posedge clk);
        #1;
        memWrite   = 1'b0;
        byteMask   = 4'd0;
        memAddress = A_STAT;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memWrite   = 1'b0;
        memAddress = a;
        #1;
        check_eq(tag, memReadData, exp);
        memAddress = A_STAT;
    endtask

    task automatic wait_idle(input string tag);
        bit done_f;
        done_f     = 1'b0;
        memAddress = A_STAT;
        for (int i = 0; i < 20000 && !done_f; i++) begin
            idle(1);
            if (memReadData[0] === 1'b0 && memReadData[2] === 1'b1) done_f = 1'b1;
        end
        check_eq(tag, {31'd0, done_f}, 32'd1);
    endtask

    initial begin
        int          fl;
        int          n;
        logic [31:0] a;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_tx_low", {31'd0, tx}, 32'd1);
        reset = 1'b1;
        rd("rst_status", A_STAT, 32'h4 | PBIT);
        rd("rst_div", A_DIV, 32'd16);
        idle(2);

        // Single frame, DIV=4, byte 0x55.
        fl = HAS_PAR ? 44 : 40;
        wr(A_DIV, 32'd4, 4'b0011);
        wr(A_DATA, 32'h55, 4'b0001);
        check_eq("sf_tx_push_edge", {31'd0, tx}, 32'd1);
        idle(1);
        check_eq("sf_tx_start", {31'd0, tx}, 32'd0);
        for (int c = 0; c < fl; c++) begin
            if (c % 4 == 1) begin
                check_eq("sf_bit", {31'd0, tx}, {31'd0, frame_bit(8'h55, c / 4)});
                check_eq("sf_busy", {31'd0, memReadData[0]}, 32'd1);
            end
            idle(1);
        end
        check_eq("sf_end_tx", {31'd0, tx}, 32'd1);
        check_eq("sf_end_busy", {31'd0, memReadData[0]}, 32'd0);

        // Back-to-back frames, DIV=2.
        fl = HAS_PAR ? 22 : 20;
        wr(A_DIV, 32'd2, 4'b0011);
        wr(A_DATA, 32'hA5, 4'b0001);
        wr(A_DATA, 32'h3C, 4'b0001);
        idle(fl - 1);
        check_eq("b2b_stop", {31'd0, tx}, 32'd1);
        idle(1);
        check_eq("b2b_start", {31'd0, tx}, 32'd0);
        check_eq("b2b_empty", {31'd0, memReadData[2]}, 32'd1);
        check_eq("b2b_busy", {31'd0, memReadData[0]}, 32'd1);
        wait_idle("b2b_drain");

        // Overflow with DIV=100.
        wr(A_DIV, 32'd100, 4'b0011);
        for (int i = 0; i < 6; i++) wr(A_DATA, 32'h10 + 32'(i), 4'b0001);
        rd("ovf_status", A_STAT, 32'hB | PBIT);
        wr(A_STAT, 32'h8, 4'b0001);
        rd("ovf_cleared", A_STAT, 32'h3 | PBIT);
        wait_idle("ovf_drain");
        rd("ovf_final", A_STAT, 32'h4 | PBIT);

        // Bus decode.
        wr(A_DATA, 32'hFF, 4'b0010);
        idle(3);
        check_eq("dec_nopush_tx", {31'd0, tx}, 32'd1);
        rd("dec_nopush_status", A_STAT, 32'h4 | PBIT);
        wr(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        rd("dec_outside", BASE + 32'hC, 32'd0);
        rd("dec_div_offset", BASE + 32'h9, 32'd100);
        rd("dec_data_read", BASE + 32'h1, 32'd0);
        idle(1);

        // Reset during bit 3 of a frame.
        wr(A_DIV, 32'd4, 4'b0011);
        wr(A_DATA, 32'hC3, 4'b0001);
        idle(17);
        check_eq("rstmid_bit3", {31'd0, tx}, 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rstmid_tx_async", {31'd0, tx}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        rd("rstmid_status", A_STAT, 32'h4 | PBIT);
        rd("rstmid_div", A_DIV, 32'd16);
        idle(60);
        check_eq("rstmid_no_residual", {31'd0, tx}, 32'd1);

        // Randomised traffic checked by the model.
        wr(A_DIV, 32'd3, 4'b0011);
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++) wr(A_DATA, $urandom, 4'($urandom) | 4'b0001);
                end
                1: begin
                    wait_idle("rnd_idle");
                    wr(A_DIV, {16'($urandom), 16'($urandom_range(0, 5))}, 4'($urandom));
                end
                2: begin
                    for (int i = 0; i < 3; i++) begin
                        if ($urandom_range(0, 3) == 0) a = BASE - 32'($urandom_range(1, 8));
                        else a = BASE + 32'($urandom_range(0, 15));
                        rd("rnd_read", a, exp_read(a));
                    end
                    idle(1);
                end
                3: wr(A_STAT, $urandom, 4'($urandom));
                4: begin
                    if ($urandom_range(0, 1) == 0) wr(A_DATA, $urandom, 4'($urandom) & 4'b1110);
                    else wr(BASE + 32'hC + 32'($urandom_range(0, 3)), $urandom, 4'hF);
                end
                default: idle($urandom_range(1, 30));
            endcase
        end
        wait_idle("rnd_drain");
        rd("final_div", A_DIV, exp_read(A_DIV));
        rd("final_status", A_STAT, exp_status());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
